pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Consumes the decode-stage branch outcome (operand equality plus branch target) and jump requests, and owns the program counter.
- Redirects fetch on taken branches and jumps, and generates the single-cycle IF/ID flush.
- Honours hazard stalls, HALT detection and debug run/step control.
- Sits between the decode-stage branch/jump logic and instruction memory; also exports a cycle counter to the debug unit.

Parameters:
- ADDR_W, 7, program-counter / instruction-memory word-address width.
- CNT_W, 32, width of the executed-cycle counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run_i  in  1  level; start continuous execution from IDLE.
- step_i  in  1  single-cycle pulse; advance one cycle while in STEP mode.
- step_mode_i  in  1  sampled in IDLE together with run_i/step_i: 1 selects STEP, 0 selects RUN.
- stall_i  in  1  load-use stall from hazard unit.
- branch_i  in  1  decode holds a conditional branch.
- branch_ne_i  in  1  0 = BEQ, 1 = BNE.
- is_equal_i  in  1  register-operand equality from decode.
- branch_addr_i  in  ADDR_W  branch target.
- jump_i  in  1  decode holds an unconditional jump (J/JAL/JR/JALR).
- jump_addr_i  in  ADDR_W  jump target.
- halt_i  in  1  decode holds HALT.
- pc_o  out  ADDR_W  current fetch address.
- pc_plus1_o  out  ADDR_W  pc_o+1, forwarded to IF/ID.
- advance_o  out  1  pipeline-register enable for this cycle.
- flush_o  out  1  clear IF/ID on this edge.
- halted_o  out  1  core halted.
- cycles_o  out  CNT_W  count of advance cycles since reset.

Behaviour:
- State machine: IDLE, RUN, STEP, HALTED. Reset enters IDLE.
- Reset values: pc_o=0, cycles_o=0, halted_o=0. advance_o and flush_o are 0 while reset is high.
- IDLE transitions:
  - run_i=1 with step_mode_i=0 goes to RUN.
  - step_mode_i=1 goes to STEP.
  - Otherwise stay in IDLE.
  - advance_o=0 in IDLE. No PC change on the transition edge itself.
- Active cycle definition: a cycle is "active" in RUN always, and in STEP only when step_i=1. In IDLE and HALTED, advance_o=0.
- advance_o (combinational) = active AND NOT stall_i AND NOT halt_i.
- take_branch = branch_i AND (is_equal_i XOR branch_ne_i).
- redirect = advance_o AND (jump_i OR take_branch).
- flush_o (combinational) = redirect.
- PC update priority on each rising edge:
  1. reset: pc_o=0.
  2. halt_i AND active: PC holds, halted_o<=1, go to HALTED.
  3. NOT active, or stall_i: PC holds.
  4. jump_i: pc_o<=jump_addr_i. Jump beats branch if both are asserted.
  5. take_branch: pc_o<=branch_addr_i.
  6. Otherwise: pc_o<=pc_o+1, modulo 2^ADDR_W (127 wraps to 0 at the default width).
- Stall suppresses redirect. The branch is re-evaluated on the first non-stalled active cycle, when forwarded operands are valid.
- pc_plus1_o = pc_o+1 with the same wrap; purely combinational.
- Targets are used as-is; no range check.
- cycles_o increments on every edge where advance_o=1, saturating at all-ones. It holds in HALTED.
- HALTED is exited only by reset. step_i and run_i are ignored there.
- step_i high in RUN has no extra effect.
- step_i held for N cycles in STEP gives N advances.
- Reset asserted mid-operation, including same cycle as a redirect or halt: reset wins, pc_o=0, state IDLE, flush_o=0.
- Latency: the redirect target appears on pc_o one cycle after the decision. Exactly one wrong-path instruction is fetched, and it is flushed.

Test Plan:
- Reset, then run_i=1 (step_mode_i=0), no branches. Required: pc_o 0,1,2,… one per cycle; cycles_o tracks; pc_o 127 followed by 0.
- RUN, pc_o=5, branch_i=1, branch_ne_i=0, is_equal_i=1, branch_addr_i=20. Required: flush_o=1 that cycle; pc_o=20 next cycle. Same with is_equal_i=0: flush_o=0, pc_o=6.
- RUN, pc_o=9, stall_i=1 for 2 cycles while branch pending (BNE, unequal, target 40), then stall_i=0. Required: pc_o holds 9; advance_o=0; flush_o=0 during stall; then flush_o=1 and pc_o=40.
- Simultaneous jump_i=1 (target 3) and taken branch (target 50). Required: pc_o=3; single flush.
- STEP mode, three 1-cycle step_i pulses separated by idle gaps. Required: pc_o advances 0→1→2→3 only on pulse cycles; cycles_o=3.
- RUN, halt_i=1 at pc_o=12. Required: halted_o=1 next cycle; pc_o frozen at 12; cycles_o frozen; step_i/run_i ignored. Reset returns pc_o=0, halted_o=0, state IDLE.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter owner with branch/jump redirect, stall, halt and run/step control
//
// Purpose: holds the fetch address, redirects it on taken branches and jumps
// resolved in decode, raises a one-cycle IF/ID flush for the single wrong-path
// fetch, and gates pipeline advance by run/step mode, hazard stalls and HALT.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   run_i, step_i,    debug run/step control; step_mode_i picks STEP vs RUN
//   step_mode_i         when leaving IDLE
//   stall_i           load-use stall from the hazard unit
//   branch_i,         conditional branch in decode (BEQ/BNE), operand
//   branch_ne_i,        equality and target
//   is_equal_i,
//   branch_addr_i
//   jump_i,           unconditional jump in decode and its target
//   jump_addr_i
//   halt_i            HALT in decode
//   pc_o, pc_plus1_o  current fetch address and its successor
//   advance_o         pipeline-register enable for this cycle
//   flush_o           clear IF/ID on this edge
//   halted_o          core has executed HALT
//   cycles_o          saturating count of advance cycles since reset
module pc_fetch_ctrl #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              step_mode_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic              branch_ne_i,
  input  logic              is_equal_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus1_o,
  output logic              advance_o,
  output logic              flush_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  cycles_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state, state_next;

  logic active;
  logic take_branch;
  logic redirect;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    active      = 1'b0;
    take_branch = branch_i & (is_equal_i ^ branch_ne_i);
    advance_o   = 1'b0;
    redirect    = 1'b0;
    flush_o     = 1'b0;

    case (state)
      IDLE: begin
        if (step_mode_i) begin
          state_next = STEP;
        end else if (run_i) begin
          state_next = RUN;
        end
      end
      RUN:     active = 1'b1;
      STEP:    active = step_i;
      default: active = 1'b0;
    endcase

    // HALT only takes effect on a cycle that would otherwise execute.
    if (active && halt_i) begin
      state_next = HALTED;
    end

    // Reset overrides everything, including a redirect decided this cycle.
    advance_o = active & ~stall_i & ~halt_i & ~reset;
    redirect  = advance_o & (jump_i | take_branch);
    flush_o   = redirect;
  end

  assign halted_o   = (state == HALTED);
  assign pc_plus1_o = pc_o + ADDR_W'(1);

  // A stalled branch does not redirect; it is re-evaluated once the stall
  // drops and forwarded operands are valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_o <= '0;
    end else if (advance_o) begin
      if (jump_i) begin
        pc_o <= jump_addr_i;
      end else if (take_branch) begin
        pc_o <= branch_addr_i;
      end else begin
        pc_o <= pc_plus1_o;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycles_o <= '0;
    end else if (advance_o && (cycles_o != {CNT_W{1'b1}})) begin
      cycles_o <= cycles_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        run_i, step_i, step_mode_i, stall_i;
  logic        branch_i, branch_ne_i, is_equal_i;
  logic [6:0]  branch_addr_i;
  logic        jump_i;
  logic [6:0]  jump_addr_i;
  logic        halt_i;
  logic [6:0]  pc_o, pc_plus1_o;
  logic        advance_o, flush_o, halted_o;
  logic [31:0] cycles_o;

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .run_i        (run_i),
    .step_i       (step_i),
    .step_mode_i  (step_mode_i),
    .stall_i      (stall_i),
    .branch_i     (branch_i),
    .branch_ne_i  (branch_ne_i),
    .is_equal_i   (is_equal_i),
    .branch_addr_i(branch_addr_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .halt_i       (halt_i),
    .pc_o         (pc_o),
    .pc_plus1_o   (pc_plus1_o),
    .advance_o    (advance_o),
    .flush_o      (flush_o),
    .halted_o     (halted_o),
    .cycles_o     (cycles_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ctrl();
    branch_i = 0; branch_ne_i = 0; is_equal_i = 0; branch_addr_i = '0;
    jump_i = 0; jump_addr_i = '0; halt_i = 0; stall_i = 0;
  endtask

  initial begin
    reset = 1; run_i = 0; step_i = 0; step_mode_i = 0;
    clear_ctrl();
    tick(); tick();
    check("reset_pc", pc_o, 0);
    check("reset_cycles", cycles_o, 0);
    check("reset_halted", halted_o, 0);
    check("reset_advance", advance_o, 0);
    check("reset_flush", flush_o, 0);

    // IDLE -> RUN: no PC change on the transition edge.
    reset = 0; run_i = 1; step_mode_i = 0;
    #1 check("idle_advance", advance_o, 0);
    tick();
    check("run_entry_pc", pc_o, 0);
    run_i = 0;
    for (int i = 0; i < 130; i++) begin
      check("seq_pc", pc_o, i % 128);
      check("seq_cycles", cycles_o, i);
      tick();
    end
    check("wrap_pc", pc_o, 2);
    tick(); tick(); tick();
    check("pc5", pc_o, 5);
    check("pc5_plus1", pc_plus1_o, 6);

    // BEQ taken at 5 -> 20.
    branch_i = 1; branch_ne_i = 0; is_equal_i = 1; branch_addr_i = 20;
    #1 check("beq_taken_flush", flush_o, 1);
    tick();
    check("beq_taken_pc", pc_o, 20);
    check("beq_cycles", cycles_o, 134);
    // BEQ not taken.
    is_equal_i = 0;
    #1 check("beq_nt_flush", flush_o, 0);
    tick();
    check("beq_nt_pc", pc_o, 21);

    // Jump to 9, then BNE pending under a 2-cycle stall.
    clear_ctrl();
    jump_i = 1; jump_addr_i = 9;
    #1 check("jump9_flush", flush_o, 1);
    tick();
    check("jump9_pc", pc_o, 9);
    clear_ctrl();
    branch_i = 1; branch_ne_i = 1; is_equal_i = 0; branch_addr_i = 40; stall_i = 1;
    for (int i = 0; i < 2; i++) begin
      #1 check("stall_advance", advance_o, 0);
      check("stall_flush", flush_o, 0);
      tick();
      check("stall_pc", pc_o, 9);
    end
    check("stall_cycles", cycles_o, 136);
    stall_i = 0;
    #1 check("bne_flush", flush_o, 1);
    tick();
    check("bne_pc", pc_o, 40);
    check("bne_cycles", cycles_o, 137);

    // Jump beats a simultaneously taken branch.
    clear_ctrl();
    jump_i = 1; jump_addr_i = 3;
    branch_i = 1; branch_ne_i = 0; is_equal_i = 1; branch_addr_i = 50;
    #1 check("jb_flush", flush_o, 1);
    tick();
    check("jb_pc", pc_o, 3);
    clear_ctrl();
    #1 check("jb_single_flush", flush_o, 0);

    // Run to 12 and halt.
    for (int i = 0; i < 9; i++) tick();
    check("pc12", pc_o, 12);
    check("pc12_cycles", cycles_o, 147);
    halt_i = 1; jump_i = 1; jump_addr_i = 70;
    #1 check("halt_advance", advance_o, 0);
    check("halt_flush", flush_o, 0);
    tick();
    clear_ctrl();
    check("halted", halted_o, 1);
    check("halt_pc", pc_o, 12);
    run_i = 1; step_i = 1;
    for (int i = 0; i < 3; i++) tick();
    check("halted_hold", halted_o, 1);
    check("halted_pc_hold", pc_o, 12);
    check("halted_cycles_hold", cycles_o, 147);
    check("halted_advance", advance_o, 0);

    // Reset leaves HALTED.
    run_i = 0; step_i = 0; reset = 1;
    tick();
    check("rst2_pc", pc_o, 0);
    check("rst2_halted", halted_o, 0);
    check("rst2_cycles", cycles_o, 0);

    // STEP mode: three single-cycle pulses separated by gaps.
    reset = 0; step_mode_i = 1;
    tick();
    step_mode_i = 0;
    #1 check("step_idle_advance", advance_o, 0);
    tick();
    check("step_gap_pc", pc_o, 0);
    for (int i = 0; i < 3; i++) begin
      step_i = 1;
      #1 check("step_advance", advance_o, 1);
      tick();
      step_i = 0;
      check("step_pc", pc_o, i + 1);
      tick();
      check("step_gap_hold", pc_o, i + 1);
    end
    check("step_cycles", cycles_o, 3);

    // Reset in the same cycle as a redirect wins.
    step_i = 1; jump_i = 1; jump_addr_i = 77; reset = 1;
    #1 check("rst_redirect_flush", flush_o, 0);
    check("rst_redirect_advance", advance_o, 0);
    tick();
    check("rst_redirect_pc", pc_o, 0);
    check("rst_redirect_cycles", cycles_o, 0);
    // Back in IDLE: step_i alone does nothing.
    reset = 0;
    #1 check("post_rst_idle_advance", advance_o, 0);
    tick();
    check("post_rst_idle_pc", pc_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
